// File: rtl/pc_fetch_pkg.sv
// Shared fetch/branch definitions: reset vector, PC word step, branch codes and
// the entry/tag record types used by the IF stage.
package pc_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] WORD_STEP            = 32'd4;

  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ, BR_JUMP
  } br_code_e;

  typedef enum logic [1:0] {
    FS_RUN, FS_HOLD, FS_WAIT_GNT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        kill;
  } fetch_tag_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead buffer of fetched {pc,instr} pairs. A flush keeps at most the
// head (after this cycle's pop/push) and only when it matches keep_pc_i.
module fetch_fifo
  import pc_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [31:0]                push_pc_i,
  input  logic [31:0]                push_instr_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [31:0]                keep_pc_i,
  output logic                       kept_o,
  output logic                       head_valid_o,
  output logic [31:0]                head_pc_o,
  output logic [31:0]                head_instr_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   count_q;

  logic [CW-1:0]   after_pop;
  logic [AW-1:0]   head_idx;
  logic            old_head;
  logic [31:0]     cand_pc;
  logic            mem_we;

  // The head that survives a flush is the oldest entry after the pop, or the
  // incoming push when the buffer would otherwise be empty.
  always_comb begin
    after_pop = count_q - CW'(pop_i);
    head_idx  = rd_q + AW'(pop_i);
    old_head  = (after_pop != '0);
    cand_pc   = old_head ? mem_q[head_idx].pc : push_pc_i;
    kept_o    = flush_i && (old_head || push_i) && (cand_pc == keep_pc_i);
    mem_we    = push_i && (!flush_i || (kept_o && !old_head));
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_q] <= '{pc: push_pc_i, instr: push_instr_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      if (!kept_o) begin
        rd_q    <= wr_q;
        count_q <= '0;
      end else if (old_head) begin
        rd_q    <= head_idx;
        wr_q    <= head_idx + AW'(1);
        count_q <= CW'(1);
      end else begin
        rd_q    <= wr_q;
        wr_q    <= wr_q + AW'(1);
        count_q <= CW'(1);
      end
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_valid_o = (count_q != '0);
  assign head_pc_o    = mem_q[rd_q].pc;
  assign head_instr_o = mem_q[rd_q].instr;
  assign count_o      = count_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// IF stage: owns the fetch PC, issues in-order imem requests under a credit
// limit, tracks in-flight tags and applies delay-slot-preserving redirects.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_slot_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d, redir_pc_q, redir_pc_d;
  logic          pend_redir_q, pend_redir_d;
  fetch_tag_t    tag_q [DEPTH];
  fetch_tag_t    tag_d [DEPTH];
  logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [CW-1:0] inflight_q, inflight_d;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   used_c;
  logic          credit_ok, issue, fifo_kept, resp_keep, seen_c;
  logic [AW-1:0] idx_c;
  fetch_tag_t    oldest_tag;

  assign used_c    = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign credit_ok = used_c < (CW+1)'(DEPTH);
  assign imem_req  = rst_n && ((state_q == FS_WAIT_GNT) || credit_ok);
  assign imem_addr = pc_q;
  assign issue     = imem_req && imem_gnt;
  assign oldest_tag = tag_q[tag_rd_q];
  // Responses are classified against kill bits before any redirect this cycle.
  assign resp_keep = imem_rvalid && !oldest_tag.kill;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (resp_keep),
    .push_pc_i    (oldest_tag.pc),
    .push_instr_i (imem_rdata),
    .pop_i        (if_valid && id_ready),
    .flush_i      (redirect_valid),
    .keep_pc_i    (redirect_slot_pc),
    .kept_o       (fifo_kept),
    .head_valid_o (if_valid),
    .head_pc_o    (if_pc),
    .head_instr_o (if_instr),
    .count_o      (fifo_count)
  );

  always_comb begin
    tag_d      = tag_q;
    tag_rd_d   = tag_rd_q + AW'(imem_rvalid);
    tag_wr_d   = tag_wr_q;
    inflight_d = inflight_q - CW'(imem_rvalid);
    seen_c     = fifo_kept;
    idx_c      = tag_rd_d;
    if (issue) begin
      tag_d[tag_wr_q] = '{pc: pc_q, kill: pend_redir_q};
      tag_wr_d        = tag_wr_q + AW'(1);
      inflight_d      = inflight_d + CW'(1);
    end
    // Only the oldest live tag may survive, and only if it is the delay slot.
    if (redirect_valid) begin
      for (int p = 0; p < DEPTH; p++) begin
        idx_c = tag_rd_d + AW'(p);
        if ((CW'(p) < inflight_d) && !tag_d[idx_c].kill) begin
          if (seen_c || (tag_d[idx_c].pc != redirect_slot_pc)) tag_d[idx_c].kill = 1'b1;
          seen_c = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pc_d         = pc_q;
    pend_redir_d = pend_redir_q;
    redir_pc_d   = redir_pc_q;
    if (issue) begin
      pc_d         = pend_redir_q ? redir_pc_q : pc_q + WORD_STEP;
      pend_redir_d = 1'b0;
    end
    if (redirect_valid) begin
      if (!imem_req || imem_gnt) begin
        pc_d         = redirect_pc;
        pend_redir_d = 1'b0;
      end else begin
        pend_redir_d = 1'b1;
        redir_pc_d   = redirect_pc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_RUN:      if (!credit_ok) state_d = FS_HOLD;
                   else if (!imem_gnt) state_d = FS_WAIT_GNT;
      FS_HOLD:     if (credit_ok) state_d = imem_gnt ? FS_RUN : FS_WAIT_GNT;
      FS_WAIT_GNT: if (imem_gnt) state_d = FS_RUN;
      default:     state_d = FS_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FS_RUN;
      pc_q         <= RESET_VECTOR;
      redir_pc_q   <= '0;
      pend_redir_q <= 1'b0;
      tag_rd_q     <= '0;
      tag_wr_q     <= '0;
      inflight_q   <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pc_q   <= redir_pc_d;
      pend_redir_q <= pend_redir_d;
      tag_rd_q     <= tag_rd_d;
      tag_wr_q     <= tag_wr_d;
      inflight_q   <= inflight_d;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: a queue-level model of the fetch rules
// predicts req/addr and the ID-facing head every cycle.
module tb_pc_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'hBFC0_0000;

  logic        clk, rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc, redirect_slot_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, id_ready;
  logic [31:0] if_pc, if_instr;

  pc_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_slot_pc (redirect_slot_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_instr         (if_instr),
    .id_ready         (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit kill; } mtag_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } mbuf_t;

  mtag_t       m_tags[$];
  mbuf_t       m_buf[$];
  logic [31:0] mem_q[$];
  logic [31:0] m_pc, m_rpc;
  bit          m_pend, m_wait, m_req;
  bit          dut_req;
  logic [31:0] dut_addr;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    m_tags.delete();
    m_buf.delete();
    mem_q.delete();
    m_pc   = RV;
    m_rpc  = '0;
    m_pend = 0;
    m_wait = 0;
  endtask

  // Applies one clock edge of the fetch rules to the queue model.
  task automatic model_step();
    mtag_t t;
    mbuf_t b;
    bit    seen;
    if (m_buf.size() > 0 && id_ready) begin
      $display("[%0t] ID consume pc=%h instr=%h", $time, m_buf[0].pc, m_buf[0].instr);
      void'(m_buf.pop_front());
    end
    if (imem_rvalid && m_tags.size() > 0) begin
      t = m_tags.pop_front();
      if (!t.kill) begin
        b.pc = t.pc; b.instr = imem_rdata;
        m_buf.push_back(b);
      end
    end
    if (m_req && imem_gnt) begin
      t.pc = m_pc; t.kill = m_pend;
      m_tags.push_back(t);
      m_pc   = m_pend ? m_rpc : m_pc + 32'd4;
      m_pend = 0;
    end
    if (redirect_valid) begin
      if (m_buf.size() > 0) begin
        b = m_buf[0];
        m_buf.delete();
        if (b.pc == redirect_slot_pc) m_buf.push_back(b);
      end
      seen = (m_buf.size() > 0);
      foreach (m_tags[i]) begin
        if (!m_tags[i].kill) begin
          if (seen || m_tags[i].pc != redirect_slot_pc) m_tags[i].kill = 1;
          seen = 1;
        end
      end
      if (!m_req || imem_gnt) begin
        m_pc = redirect_pc; m_pend = 0;
      end else begin
        m_pend = 1; m_rpc = redirect_pc;
      end
    end
    m_wait = m_req && !imem_gnt;
  endtask

  task automatic run_phase(input int n, input int gnt_pct, input int rv_pct,
                           input int rdy_pct, input int redir_pct);
    for (int c = 0; c < n && n_err < 40; c++) begin
      m_req = ((m_tags.size() + m_buf.size()) < DEPTH) || m_wait;
      check_eq("imem_req", 32'(imem_req), 32'(m_req));
      if (m_req) check_eq("imem_addr", imem_addr, m_pc);
      check_eq("if_valid", 32'(if_valid), 32'(m_buf.size() > 0));
      if (m_buf.size() > 0) begin
        check_eq("if_pc", if_pc, m_buf[0].pc);
        check_eq("if_instr", if_instr, m_buf[0].instr);
      end
      dut_req  = imem_req;
      dut_addr = imem_addr;
      imem_gnt    = int'($urandom_range(0, 99)) < gnt_pct;
      imem_rvalid = (mem_q.size() > 0) && (int'($urandom_range(0, 99)) < rv_pct);
      imem_rdata  = imem_rvalid ? instr_of(mem_q[0]) : $urandom;
      id_ready    = int'($urandom_range(0, 99)) < rdy_pct;
      redirect_valid = int'($urandom_range(0, 99)) < redir_pct;
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'h8000_1000;
        1:       redirect_pc = 32'hFFFF_FFF8;
        default: redirect_pc = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
      endcase
      case ($urandom_range(0, 3))
        0:       redirect_slot_pc = (m_buf.size() > 0) ? m_buf[0].pc : m_pc;
        1:       redirect_slot_pc = (m_tags.size() > 0) ? m_tags[0].pc : m_pc;
        2:       redirect_slot_pc = m_pc;
        default: redirect_slot_pc = m_pc + 32'd4;
      endcase
      @(posedge clk);
      model_step();
      if (imem_rvalid) void'(mem_q.pop_front());
      if (dut_req && imem_gnt) mem_q.push_back(dut_addr);
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; id_ready = 0;
    redirect_valid = 0; redirect_pc = '0; redirect_slot_pc = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    check_eq("reset_req", 32'(imem_req), 32'd0);
    check_eq("reset_if_valid", 32'(if_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_phase(60, 100, 100, 100, 0);   // steady stream from the reset vector
    run_phase(40, 100, 100, 0, 0);     // ID stalled: credits cap outstanding work
    run_phase(150, 100, 80, 70, 8);    // redirects with slot at head / in flight
    run_phase(150, 35, 60, 60, 12);    // long grant stalls with redirects
    run_phase(12, 100, 100, 0, 0);     // fill the buffer before a mid-run reset
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_req", 32'(imem_req), 32'd0);
    check_eq("async_rst_if_valid", 32'(if_valid), 32'd0);
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("restart_addr", imem_addr, RV);
    run_phase(250, 70, 70, 70, 6);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
